// File: rtl/onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : onehot_rr_arbiter
// Brief    : 8-lane round-robin arbiter with one-hot and encoded grant outputs.
//            Forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
// Revision : 1.0
// ============================================================================
module onehot_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [2:0] w_sel;
  logic       w_norm_rel;
  logic       w_force;
  logic       w_release;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_check
    $error("onehot_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  // Scan downward in offset so the nearest set bit at or above r_ptr wins.
  always_comb begin
    w_sel = r_ptr;
    for (int i = 7; i >= 0; i--) begin
      if (req[r_ptr + 3'(i)]) begin
        w_sel = r_ptr + 3'(i);
      end
    end
  end

  assign w_norm_rel = done | ~req[grant_idx];
  assign w_release  = w_norm_rel | w_force;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= 3'd0;
      grant       <= 8'h00;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            grant       <= 8'h01 << w_sel;
            grant_idx   <= w_sel;
            grant_valid <= 1'b1;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          // grant_idx is deliberately left holding the last owner.
          if (w_release) begin
            grant       <= 8'h00;
            grant_valid <= 1'b0;
            r_ptr       <= grant_idx + 3'd1;
            r_state     <= S_GAP;
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold;
  logic       r_timeout;

  // A normal release on the same edge suppresses the forced one.
  assign w_force = (r_hold == 8'(MAX_HOLD)) & ~w_norm_rel;
  assign timeout = r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_hold <= (|req) ? 8'd1 : 8'd0;
        end
        S_GRANT: begin
          if (w_release) begin
            r_hold    <= 8'd0;
            r_timeout <= w_force;
          end else begin
            r_hold <= r_hold + 8'd1;
          end
        end
        default: begin
          r_hold <= 8'd0;
        end
      endcase
    end
  end
`else
  assign w_force = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_rr_arbiter
// Brief    : Self-checking bench for onehot_rr_arbiter (table, corner cases,
//            randomized traffic against a reference model).
// Revision : 1.0
// ============================================================================
module tb_onehot_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int c_max_hold = 4;
  localparam bit c_to_en    = 1'b1;
`else
  localparam int c_max_hold = 16;
  localparam bit c_to_en    = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  onehot_rr_arbiter #(.MAX_HOLD(c_max_hold)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: which lane owns the resource, how long it has held it,
  // and how many idle cycles remain before the next arbitration may occur.
  int m_ptr, m_owner, m_last, m_held, m_wait;
  bit m_tout;

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_last = 0; m_held = 0; m_wait = 0; m_tout = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    m_tout = 0;
    if (m_owner >= 0) begin
      m_held++;
      if (d || !r[m_owner] || (c_to_en && m_held >= c_max_hold)) begin
        m_tout  = c_to_en && !d && r[m_owner];
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_wait  = 1;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (r != 8'h00) begin
      for (int k = 0; k < 8; k++) begin
        if (r[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          break;
        end
      end
      m_last = m_owner;
      m_held = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_invariants();
    chk("inv_valid_eq_or", 32'(grant_valid), 32'(|grant));
    if (grant_valid) chk("inv_onehot_idx", 32'(grant), 32'(8'h01 << grant_idx));
  endtask

  task automatic chk_model(input string tag);
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    chk({tag, "_grant"},   32'(grant),       32'(eg));
    chk({tag, "_idx"},     32'(grant_idx),   32'(m_last));
    chk({tag, "_valid"},   32'(grant_valid), 32'(m_owner >= 0));
    chk({tag, "_timeout"}, 32'(timeout),     32'(m_tout));
  endtask

  // Drive inputs, take one rising edge, advance the model, settle 1ns.
  task automatic cycle(input logic [7:0] r, input logic d);
    req = r; done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
  endtask

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] idx;
    logic       valid;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic [7:0] r, input logic d, input logic [7:0] g,
                   input logic [2:0] i, input logic val);
    vec_t e;
    e.req = r; e.done = d; e.grant = g; e.idx = i; e.valid = val;
    vecs.push_back(e);
  endtask

  initial begin
    // Rotation, req-drop release, simultaneous done/req, done outside GRANT,
    // pointer wrap past lane 6, non-owner req changes ignored.
    v(8'hFF,1,8'h01,0,1); v(8'hFF,1,8'h00,0,0); v(8'hFF,0,8'h00,0,0);
    v(8'hFF,0,8'h02,1,1); v(8'hFF,1,8'h00,1,0); v(8'hFF,0,8'h00,1,0);
    v(8'hFF,0,8'h04,2,1); v(8'hFB,0,8'h00,2,0); v(8'h08,0,8'h00,2,0);
    v(8'h08,0,8'h08,3,1); v(8'h28,1,8'h00,3,0); v(8'h28,0,8'h00,3,0);
    v(8'h28,0,8'h20,5,1); v(8'h20,1,8'h00,5,0); v(8'h00,1,8'h00,5,0);
    v(8'h00,1,8'h00,5,0); v(8'h41,0,8'h40,6,1); v(8'h41,1,8'h00,6,0);
    v(8'h41,0,8'h00,6,0); v(8'h41,0,8'h01,0,1); v(8'h41,1,8'h00,0,0);
    v(8'h41,0,8'h00,0,0); v(8'h41,0,8'h40,6,1); v(8'hC0,0,8'h40,6,1);
    v(8'h41,1,8'h00,6,0);

    // Reset held with all lanes requesting.
    req = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_idx", 32'(grant_idx), 32'h0);
    chk("reset_valid", 32'(grant_valid), 32'h0);
    chk("reset_timeout", 32'(timeout), 32'h0);
    rst_n = 1'b1;
    model_reset();

    // The first table row's done is ignored in IDLE and yields lane 0.
    foreach (vecs[n]) begin
      cycle(vecs[n].req, vecs[n].done);
      chk($sformatf("vec%0d_grant", n), 32'(grant), 32'(vecs[n].grant));
      chk($sformatf("vec%0d_idx", n), 32'(grant_idx), 32'(vecs[n].idx));
      chk($sformatf("vec%0d_valid", n), 32'(grant_valid), 32'(vecs[n].valid));
      chk($sformatf("vec%0d_timeout", n), 32'(timeout), 32'h0);
      chk_invariants();
    end

    // Asynchronous reset in the middle of a grant.
    cycle(8'h10, 1'b0);
    cycle(8'h10, 1'b0);
    chk_model("pre_areset");
    chk("pre_areset_valid", 32'(grant_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_grant", 32'(grant), 32'h0);
    chk("areset_idx", 32'(grant_idx), 32'h0);
    chk("areset_valid", 32'(grant_valid), 32'h0);
    req = 8'hFF;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    cycle(8'hFF, 1'b0);
    chk("post_areset_grant", 32'(grant), 32'h01);
    chk("post_areset_idx", 32'(grant_idx), 32'h0);

    // Single requester: granted, released, re-granted every 3 cycles.
    for (int k = 0; k < 9; k++) begin
      cycle(8'h04, (k % 3) == 0);
      chk_model("single");
    end

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      logic [7:0] r;
      logic d;
      r = 8'($urandom);
      if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
      d = ($urandom_range(0, 3) == 0);
      cycle(r, d);
      chk_model("rand");
      chk_invariants();
    end

    // Long hold by lane 1 with done never asserted.
    repeat (3) cycle(8'h00, 1'b0);
    for (int k = 0; k < 100; k++) begin
      cycle(8'h02, 1'b0);
      chk_model("hold");
    end
`ifndef ARB_TIMEOUT_EN
    chk("hold_still_valid", 32'(grant_valid), 32'h1);
    chk("hold_still_grant", 32'(grant), 32'h02);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
